// File: rtl/instr_queue_reg_if.sv
// ---------------------------------------------------------------------------
// instr_queue_reg_if : fetch-side valid/ready bus for the instruction queue.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface instr_queue_reg_if #(
  parameter int INSTR_W = 32
);
  logic               in_valid;
  logic               in_ready;
  logic [INSTR_W-1:0] instruction;

  modport master (output in_valid, output instruction, input in_ready);
  modport slave  (input in_valid, input instruction, output in_ready);
endinterface

`default_nettype wire

// File: rtl/instr_queue_reg.sv
// ---------------------------------------------------------------------------
// instr_queue_reg : DEPTH-entry instruction FIFO feeding a decoded IR.
// Optional macro INSTR_QUEUE_SIGN_EXT_EN selects sign- instead of zero-extension of imm.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module instr_queue_reg #(
  parameter int INSTR_W = 32,
  parameter int DEPTH   = 4,
  parameter int OPC_W   = 6,
  parameter int REG_W   = 5,
  parameter int IMM_W   = 16,
  parameter int EXT_W   = 32,
  parameter int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  instr_queue_reg_if.slave        fetch,
  input  logic                    ir_write,
  output logic                    ir_valid,
  output logic [OPC_W-1:0]        opcode,
  output logic [REG_W-1:0]        r1,
  output logic [REG_W-1:0]        r2,
  output logic [REG_W-1:0]        r3,
  output logic [IMM_W-1:0]        imm,
  output logic [EXT_W-1:0]        imm_ext,
  output logic [CNT_W-1:0]        count
);

  localparam int              PTR_W      = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  logic [INSTR_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [INSTR_W-1:0] ir;
  logic               empty;
  logic               do_push;
  logic               do_pop;

  // Ready depends only on registered occupancy, never on a same-cycle pop.
  assign fetch.in_ready = (count != FULL_COUNT);
  assign empty          = (count == '0);
  assign do_push        = fetch.in_valid && fetch.in_ready && !flush;
  assign do_pop         = ir_write && !empty && !flush;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= fetch.instruction;
    end
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Flush invalidates but keeps IR contents; an empty advance inserts a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir       <= '0;
      ir_valid <= 1'b0;
    end else if (flush) begin
      ir_valid <= 1'b0;
    end else if (ir_write) begin
      if (!empty) begin
        ir       <= mem[rd_ptr];
        ir_valid <= 1'b1;
      end else begin
        ir_valid <= 1'b0;
      end
    end
  end

  assign opcode = ir[INSTR_W-1 -: OPC_W];
  assign r1     = ir[INSTR_W-OPC_W-1 -: REG_W];
  assign r2     = ir[INSTR_W-OPC_W-REG_W-1 -: REG_W];
  assign r3     = ir[INSTR_W-OPC_W-2*REG_W-1 -: REG_W];
  assign imm    = ir[IMM_W-1:0];

`ifdef INSTR_QUEUE_SIGN_EXT_EN
  assign imm_ext = EXT_W'($signed(imm));
`else
  assign imm_ext = EXT_W'(imm);
`endif

endmodule

`default_nettype wire

// File: tb/tb_instr_queue_reg.sv
// ---------------------------------------------------------------------------
// tb_instr_queue_reg : directed stimulus with a scoreboard-driven IR monitor.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_instr_queue_reg;

  typedef logic [31:0] word_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        ir_write = 1'b0;
  logic        ir_valid;
  logic [5:0]  opcode;
  logic [4:0]  r1, r2, r3;
  logic [15:0] imm;
  logic [31:0] imm_ext;
  logic [2:0]  count;

  int    n_pass  = 0;
  int    n_total = 0;
  word_t sb[$];
  logic  mon_wr;
  word_t mon_exp;

  instr_queue_reg_if #(.INSTR_W(32)) fetch ();

  instr_queue_reg dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .fetch    (fetch),
    .ir_write (ir_write),
    .ir_valid (ir_valid),
    .opcode   (opcode),
    .r1       (r1),
    .r2       (r2),
    .r3       (r3),
    .imm      (imm),
    .imm_ext  (imm_ext),
    .count    (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic word_t exp_ext(input word_t w);
`ifdef INSTR_QUEUE_SIGN_EXT_EN
    return {{16{w[15]}}, w[15:0]};
`else
    return {16'h0000, w[15:0]};
`endif
  endfunction

  // Monitor: each successful IR load is matched against the oldest expected word.
  always @(posedge clk) begin
    mon_wr = ir_write && !rst;
    #2;
    if (mon_wr && ir_valid) begin
      if (sb.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_load: got ir opcode=%h imm=%h expected no load", opcode, imm);
      end else begin
        mon_exp = sb.pop_front();
        check("sb_opcode",  {26'd0, opcode}, {26'd0, mon_exp[31:26]});
        check("sb_r1",      {27'd0, r1},     {27'd0, mon_exp[25:21]});
        check("sb_r2",      {27'd0, r2},     {27'd0, mon_exp[20:16]});
        check("sb_r3",      {27'd0, r3},     {27'd0, mon_exp[15:11]});
        check("sb_imm",     {16'd0, imm},    {16'd0, mon_exp[15:0]});
        check("sb_imm_ext", imm_ext,         exp_ext(mon_exp));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input bit v, input word_t w, input bit rd, input bit fl,
                      input bit expect_load, input word_t exp_w);
    fetch.in_valid    = v;
    fetch.instruction = w;
    ir_write          = rd;
    flush             = fl;
    if (expect_load) sb.push_back(exp_w);
    tick();
    fetch.in_valid = 1'b0;
    ir_write       = 1'b0;
    flush          = 1'b0;
  endtask

  task automatic push(input word_t w);
    step(1'b1, w, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic pop(input word_t w);
    step(1'b0, '0, 1'b1, 1'b0, 1'b1, w);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    fetch.in_valid    = 1'b0;
    fetch.instruction = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_count",    {29'd0, count},          32'd0);
    check("rst_in_ready", {31'd0, fetch.in_ready}, 32'd1);
    check("rst_ir_valid", {31'd0, ir_valid},       32'd0);
    check("rst_imm_ext",  imm_ext,                 32'd0);

    // Decode vector
    push(32'h8C22_FFFC);
    check("dec_count_push", {29'd0, count}, 32'd1);
    pop(32'h8C22_FFFC);
    check("dec_ir_valid", {31'd0, ir_valid}, 32'd1);
    check("dec_opcode",   {26'd0, opcode},   32'h23);
    check("dec_r1",       {27'd0, r1},       32'd1);
    check("dec_r2",       {27'd0, r2},       32'd2);
    check("dec_r3",       {27'd0, r3},       32'd31);
    check("dec_imm",      {16'd0, imm},      32'h0000_FFFC);
`ifdef INSTR_QUEUE_SIGN_EXT_EN
    check("dec_imm_ext",  imm_ext,           32'hFFFF_FFFC);
`else
    check("dec_imm_ext",  imm_ext,           32'h0000_FFFC);
`endif
    check("dec_count_pop", {29'd0, count}, 32'd0);

    // Fill, reject while full, then wrap
    push(32'h0421_8001);
    push(32'h0842_4002);
    push(32'h0C63_2003);
    push(32'h1084_1004);
    check("full_count",    {29'd0, count},          32'd4);
    check("full_in_ready", {31'd0, fetch.in_ready}, 32'd0);
    step(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b1, 32'h0421_8001);
    check("full_pop_no_push", {29'd0, count},       32'd3);
    check("full_ready_back", {31'd0, fetch.in_ready}, 32'd1);
    pop(32'h0842_4002);
    push(32'h14A5_0805);
    push(32'h18C6_F406);
    check("wrap_count", {29'd0, count}, 32'd4);
    pop(32'h0C63_2003);
    pop(32'h1084_1004);
    pop(32'h14A5_0805);
    pop(32'h18C6_F406);
    check("wrap_drain", {29'd0, count}, 32'd0);

    // Simultaneous push and pop
    push(32'h1CE7_0107);
    push(32'h2108_8208);
    step(1'b1, 32'h2529_4309, 1'b1, 1'b0, 1'b1, 32'h1CE7_0107);
    check("sim_count", {29'd0, count}, 32'd2);
    pop(32'h2108_8208);
    pop(32'h2529_4309);

    // Empty: push with advance gives a bubble
    step(1'b1, 32'h0000_0001, 1'b1, 1'b0, 1'b0, '0);
    check("empty_count",    {29'd0, count},    32'd1);
    check("empty_ir_valid", {31'd0, ir_valid}, 32'd0);
    pop(32'h0000_0001);
    check("empty_ir_valid2", {31'd0, ir_valid}, 32'd1);
    check("empty_imm",       {16'd0, imm},      32'd1);
    check("empty_count2",    {29'd0, count},    32'd0);

    // Flush drops queue, push and advance; IR fields hold
    push(32'h2D6B_A00B);
    push(32'h318C_500C);
    push(32'h35AD_280D);
    check("flush_pre_count", {29'd0, count}, 32'd3);
    step(1'b1, 32'hCAFE_F00D, 1'b1, 1'b1, 1'b0, '0);
    check("flush_count",    {29'd0, count},    32'd0);
    check("flush_ir_valid", {31'd0, ir_valid}, 32'd0);
    check("flush_imm_hold", {16'd0, imm},      32'd1);
    check("flush_opc_hold", {26'd0, opcode},   32'd0);
    push(32'h39CE_140E);
    pop(32'h39CE_140E);
    check("flush_after_imm", {16'd0, imm}, 32'h0000_140E);

    // Asynchronous reset mid-cycle
    push(32'h3DEF_0A0F);
    push(32'h4210_0510);
    push(32'h4631_8211);
    pop(32'h3DEF_0A0F);
    #2 rst = 1'b1;
    #1;
    check("arst_count",    {29'd0, count},          32'd0);
    check("arst_in_ready", {31'd0, fetch.in_ready}, 32'd1);
    check("arst_ir_valid", {31'd0, ir_valid},       32'd0);
    check("arst_fields",   {opcode, r1, r2, imm},   32'd0);
    check("arst_r3",       {27'd0, r3},             32'd0);
    tick();
    rst = 1'b0;
    tick();

    check("sb_empty", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/instr_queue_reg.md
Name: instr_queue_reg

Overview:
- Parametrised successor to the single-stage instruction register.
- Buffers fetched instruction words in a DEPTH-entry FIFO ahead of the IR, using a valid/ready handshake on the fetch side.
- Loads the IR from the FIFO head on IRWrite and decodes it into opcode, three register fields and an immediate, with a zero- or sign-extended copy of the immediate.
- Sits between instruction memory fetch and the control/decode stage; adds flush for branch redirect.

Parameters:
- INSTR_W, 32, instruction word width.
- DEPTH, 4, FIFO entries; must be a power of two and at least 2.
- OPC_W, 6, opcode field width (MSBs of the word).
- REG_W, 5, width of each register-specifier field.
- IMM_W, 16, immediate field width (LSBs of the word).
- EXT_W, 32, width of the extended immediate; must be at least IMM_W.
- CNT_W, $clog2(DEPTH+1), width of the Count port.

Ports:
- Clk  in  1  rising-edge clock.
- Rst  in  1  asynchronous reset, active-high.
- Flush  in  1  discard all queued words and invalidate the IR.
- InValid  in  1  fetch side presents a word.
- InReady  out  1  queue can accept a word this cycle.
- Instruction  in  INSTR_W  fetched instruction word.
- IRWrite  in  1  advance: load the FIFO head into the IR.
- IRValid  out  1  IR holds a valid instruction.
- Opcode  out  OPC_W  IR[INSTR_W-1 -: OPC_W].
- R1  out  REG_W  next REG_W bits below the opcode.
- R2  out  REG_W  next REG_W bits below R1.
- R3  out  REG_W  next REG_W bits below R2.
- Imm  out  IMM_W  IR[IMM_W-1:0]. Overlaps R3 and lower bits by design.
- ImmExt  out  EXT_W  extended Imm.
- Count  out  CNT_W  number of words currently queued (0..DEPTH).

Behaviour:
- Reset (async, Rst=1): FIFO pointers and Count are 0, IR is 0, IRValid is 0. Every field output is therefore 0 and InReady is 1. Reset asserted mid-operation discards all contents immediately, without waiting for a clock edge.
- InReady = (Count != DEPTH). It is a function of registered state only; it does not depend on IRWrite in the same cycle.
- Push: when InValid && InReady at a rising edge, Instruction is written at the write pointer, and the write pointer increments modulo DEPTH (wraps from DEPTH-1 to 0).
- Pop: when IRWrite && Count != 0 at a rising edge:
  - IR <= FIFO head.
  - Read pointer increments modulo DEPTH.
  - IRValid <= 1.
- IRWrite while empty (Count == 0): IR holds its value, IRValid <= 0 (bubble).
- IRWrite = 0: IR and IRValid hold.
- Simultaneous push and pop: both take effect and Count is unchanged.
- No bypass: a word pushed at edge N is loaded into the IR no earlier than edge N+1. Minimum latency from Instruction to the decoded outputs is 2 edges.
- Full (Count == DEPTH): InReady = 0, so no push occurs even if IRWrite pops in that cycle. InReady rises the cycle after the pop.
- Empty with push and IRWrite in the same cycle: the word enters the FIFO, Count becomes 1, IRValid <= 0.
- Flush (synchronous, highest priority after Rst):
  - Count <= 0, pointers <= 0, IRValid <= 0.
  - Any push or IRWrite in the same cycle is ignored.
  - IR contents and field outputs hold their last value.
- Field outputs are combinational slices of the IR register. They are valid whenever IRValid = 1.
- Count updates by +1, -1 or 0 per edge and never exceeds DEPTH or goes below 0.

Optional Feature:
- Macro: INSTR_QUEUE_SIGN_EXT_EN.
- Defined: ImmExt = Imm sign-extended to EXT_W (replicates Imm[IMM_W-1]).
- Undefined: ImmExt = Imm zero-extended to EXT_W.
- Imm itself is identical in both builds.

Test Plan:
- Reset: Rst=1 asynchronously mid-cycle after 3 pushes -> Count=0, IRValid=0, Opcode/R1/R2/R3/Imm=0, InReady=1 immediately, before the next edge.
- Decode: push 32'h8C22_FFFC, then IRWrite -> IRValid=1, Opcode=6'h23, R1=5'd1, R2=5'd2, R3=5'd31, Imm=16'hFFFC. ImmExt=32'hFFFF_FFFC with the macro defined, 32'h0000_FFFC without.
- Full/wrap: push 4 words (DEPTH=4) -> Count=4, InReady=0, and a 5th InValid is not accepted. Then pop 2 and push 2 -> the words exit in push order across the pointer wrap.
- Simultaneous: Count=2, then push and IRWrite in one cycle -> Count stays 2, IR = oldest word.
- Empty edge case: Count=0, push 32'h0000_0001 with IRWrite in the same cycle -> Count=1, IRValid=0. Next IRWrite -> IR=32'h0000_0001, IRValid=1, Count=0.
- Flush: Count=3 with IRValid=1, then Flush together with push and IRWrite -> Count=0, IRValid=0, IR fields unchanged, the pushed word is dropped.
